ysyx_22050518_mul_final_add: RTL and testbench
==============================================

# ysyx_22050518_mul_final_add

Final stage of the pipelined RV64 multiplier, directly downstream of the column-compression Wallace tree. It tracks each issued multiply through the tree's fixed register latency with a tag pipeline. It resolves the tree's per-column sum/carry vectors with a two-stage carry-propagate adder, selects the RV64M result field, and holds the result under a valid/ready handshake toward writeback.

## Interface
- `XLEN`, 64: operand/result width.
- `COLS`, 132: tree column count; the width of `tree_s` and `tree_c`.
- `TREE_LAT`, 8: register stages between issue and tree output.

- `clk`, input, 1: clock, rising edge.
- `rst_n`, input, 1: reset, asynchronous, active-low.
- `issue_valid`, input, 1: a multiply enters the Booth/tree front end this cycle.
- `issue_op`, input, 2: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU.
- `issue_word`, input, 1: MULW; forces MUL selection with 32→64 sign extension.
- `flush`, input, 1: discard every in-flight and held operation.
- `tree_s`, input, COLS: per-column sum bits from the tree.
- `tree_c`, input, COLS: per-column carry bits. The carry of column i has weight 2^(i+1).
- `res_valid`, output, 1: `res_data` is valid.
- `res_ready`, input, 1: the consumer accepts the result.
- `res_data`, output, XLEN: the selected result.
- `busy`, output, 1: the block cannot accept `issue_valid`.

## Operation
- **Tag pipeline.** It is TREE_LAT entries deep, each {valid, op, word}, and shifts every cycle. Entry 0 is loaded with `issue_valid & ~busy`. `issue_valid` while `busy` is a protocol violation: the request is dropped and an assertion fires.
- **Stage A.** Active when the last tag entry is valid. Computes P = tree_s + (tree_c << 1), modulo 2^COLS, split at bit 64:
  - register lo = P[63:0] (low half only) and the carry out of bit 63;
  - register the unadded high slices of `tree_s` and `tree_c` and the tag.
- **Stage B.** Computes hi = high slices + carry, taking bits [127:64] of P; bits at 128 and above are discarded. It then loads the result register:
  - MUL: lo;
  - MULH, MULHSU, MULHU: hi;
  - word=1, any op: {32{lo[31]}, lo[31:0]}.
- Operand signedness is handled upstream. This block only selects the field.
- **Result register.** `res_valid` rises when stage B completes and falls on the edge where `res_valid & res_ready`. `res_data` stays stable while it is held.
- **busy** = (any tag, stage A or stage B valid) | (res_valid & ~res_ready). At most one operation is in flight, so the held result can never be overwritten.
- **flush** clears all tag, stage-A, stage-B and result valids at the next edge. `flush` has priority over an issue in the same cycle.
- **Reset** (asynchronous, any time): all valids 0, `res_data` 0, `busy` 0, `res_valid` 0. Datapath registers are also cleared.

## Timing
- Issue at edge T. Tree data is sampled at the end of cycle T+TREE_LAT. The stage-A register loads at T+TREE_LAT+1. `res_valid` is first high in cycle T+TREE_LAT+2, which is 10 cycles with the defaults.
- `res_valid & res_ready` in cycle N clears `res_valid` at N+1.
- Back-to-back issue is allowed: an issue in cycle N is accepted in the same cycle the previous result is consumed, because `busy` drops combinationally when `res_ready` is high.
- `busy` is registered-state-derived except for the `res_ready` term.
- Critical path: one 65-bit add per stage.

## Structure
- **Package `ysyx_22050518_mul_pkg`:**
  - the op encoding `mul_op_e` {MUL, MULH, MULHSU, MULHU};
  - the tag struct {valid, op, word};
  - the constants XLEN, COLS and TREE_LAT.
- **Sub-module `ysyx_22050518_mul_tag_pipe`:** a parameterised TREE_LAT-deep tag shift register with synchronous flush and asynchronous reset. It is shared with the tree wrapper's debug probes.
- **Top:** stages A and B, field select, result register and handshake.

## Test plan
- **Basic MUL.** Issue MUL, drive tree_s = 15, tree_c = 0 at T+8. Required: `res_valid` at T+10, `res_data` = 15, `busy` high during T+1..T+10.
- **Cross-half carry.** Drive tree_s = 2^64−2 and tree_c[0] = 1, so P = 2^64.
  - MUL: 0.
  - MULHU: 1.
  - Also check that bits ≥128 are discarded.
- **MULW sign extension.** Drive P = 0x8000_0000. Required: `res_data` = 0xFFFF_FFFF_8000_0000.
- **Backpressure.** Hold `res_ready` = 0 for 5 cycles after `res_valid`. Required:
  - `res_data` and `res_valid` stable, `busy` = 1;
  - an `issue_valid` during this window is dropped and the assertion fires;
  - `res_ready` = 1 with a simultaneous issue completes the handoff, and the next result arrives 10 cycles later.
- **Flush mid-flight.** Assert `flush` at T+4. Required: no `res_valid` ever; `busy` = 0 at T+5.
- **Asynchronous reset mid-flight.** Drop `rst_n` at T+9 mid-cycle. Required: `res_valid`, `res_data` and `busy` go to 0 without waiting for a clock edge, and no result appears after release.

Source files
------------

// File: rtl/ysyx_22050518_mul_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050518_mul_pkg
// Shared types and constants for the RV64 multiplier back end.
//   XLEN     : operand/result width
//   COLS     : Wallace tree column count (width of tree_s / tree_c)
//   TREE_LAT : register stages between issue and tree output
//   mul_op_e : RV64M multiply op encoding
//   mul_tag_t: per-operation tag carried alongside the tree
// ---------------------------------------------------------------------------
package ysyx_22050518_mul_pkg;

    localparam int XLEN     = 64;
    localparam int COLS     = 132;
    localparam int TREE_LAT = 8;

    typedef enum logic [1:0] {
        MUL    = 2'd0,
        MULH   = 2'd1,
        MULHSU = 2'd2,
        MULHU  = 2'd3
    } mul_op_e;

    typedef struct packed {
        logic    valid;
        mul_op_e op;
        logic    word;
    } mul_tag_t;

    // MULW result: low 32 bits sign-extended to XLEN.
    function automatic logic [XLEN-1:0] sext_word(input logic [31:0] v);
        return {{(XLEN-32){v[31]}}, v};
    endfunction

endpackage

// File: rtl/ysyx_22050518_mul_final_add_if.sv
// ---------------------------------------------------------------------------
// ysyx_22050518_mul_final_add_if
// Bundles the issue side, tree data and the writeback handshake of the
// multiplier final-add stage.
//   master : upstream/writeback side (drives issue, tree data, res_ready)
//   slave  : final-add block (drives res_valid, res_data, busy)
// ---------------------------------------------------------------------------
interface ysyx_22050518_mul_final_add_if;
    import ysyx_22050518_mul_pkg::*;

    logic            issue_valid;
    logic [1:0]      issue_op;
    logic            issue_word;
    logic            flush;
    logic [COLS-1:0] tree_s;
    logic [COLS-1:0] tree_c;
    logic            res_valid;
    logic            res_ready;
    logic [XLEN-1:0] res_data;
    logic            busy;

    modport master (
        output issue_valid, issue_op, issue_word, flush, tree_s, tree_c, res_ready,
        input  res_valid, res_data, busy
    );

    modport slave (
        input  issue_valid, issue_op, issue_word, flush, tree_s, tree_c, res_ready,
        output res_valid, res_data, busy
    );

endinterface

// File: rtl/ysyx_22050518_mul_tag_pipe.sv
// ---------------------------------------------------------------------------
// ysyx_22050518_mul_tag_pipe
// DEPTH-deep shift register of {valid, op, word} tags that tracks each
// multiply through the tree's fixed register latency.
//   clk, rst_n : clock, async active-low reset
//   flush      : synchronous clear of every entry
//   tag_in     : entry 0 load value (valid already qualified by the caller)
//   tag_out    : last entry, aligned with the tree output
//   any_valid  : OR of every entry's valid bit
// ---------------------------------------------------------------------------
module ysyx_22050518_mul_tag_pipe
    import ysyx_22050518_mul_pkg::*;
#(
    parameter int DEPTH = TREE_LAT
) (
    input  logic     clk,
    input  logic     rst_n,
    input  logic     flush,
    input  mul_tag_t tag_in,
    output mul_tag_t tag_out,
    output logic     any_valid
);

    mul_tag_t stages [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else if (flush) begin
            for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
        end else begin
            stages[0] <= tag_in;
            for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
        end
    end

    always_comb begin
        any_valid = 1'b0;
        for (int i = 0; i < DEPTH; i++) any_valid = any_valid | stages[i].valid;
    end

    assign tag_out = stages[DEPTH-1];

endmodule

// File: rtl/ysyx_22050518_mul_final_add.sv
// ---------------------------------------------------------------------------
// ysyx_22050518_mul_final_add
// Final stage of the pipelined RV64 multiplier: resolves the tree's
// sum/carry columns with a two-stage carry-propagate adder, selects the
// RV64M result field and holds it under a valid/ready handshake.
//   clk, rst_n : clock, async active-low reset
//   bus        : slave side of ysyx_22050518_mul_final_add_if
// ---------------------------------------------------------------------------
module ysyx_22050518_mul_final_add
    import ysyx_22050518_mul_pkg::*;
(
    input  logic                          clk,
    input  logic                          rst_n,
    ysyx_22050518_mul_final_add_if.slave  bus
);

    logic            issue_accept;
    logic            issue_dropped;
    mul_tag_t        tag_in;
    mul_tag_t        tag_tail;
    logic            tag_busy;

    logic [XLEN:0]   lo_sum;
    logic            a_valid;
    mul_op_e         a_op;
    logic            a_word;
    logic [XLEN-1:0] a_lo;
    logic            a_cy;
    logic [XLEN-1:0] a_s_hi;
    logic [XLEN-1:0] a_c_hi;

    logic [XLEN-1:0] hi_sum;
    logic [XLEN-1:0] sel;

    logic            res_valid_q;
    logic [XLEN-1:0] res_data_q;
    logic            busy;

    // Flush wins over a same-cycle issue.
    assign issue_accept  = bus.issue_valid & ~busy & ~bus.flush;
    assign issue_dropped = bus.issue_valid & busy;

    assign tag_in = '{valid: issue_accept,
                      op:    mul_op_e'(bus.issue_op),
                      word:  bus.issue_word};

    ysyx_22050518_mul_tag_pipe #(
        .DEPTH (TREE_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (bus.flush),
        .tag_in    (tag_in),
        .tag_out   (tag_tail),
        .any_valid (tag_busy)
    );

    // Stage A: low half of P = s + (c << 1). The carry vector is shifted
    // by one, so c[62:0] lands on bits [63:1] and c[63] is the first
    // carry bit belonging to the high half.
    assign lo_sum = {1'b0, bus.tree_s[XLEN-1:0]} + {1'b0, bus.tree_c[XLEN-2:0], 1'b0};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_valid <= 1'b0;
            a_op    <= MUL;
            a_word  <= 1'b0;
            a_lo    <= '0;
            a_cy    <= 1'b0;
            a_s_hi  <= '0;
            a_c_hi  <= '0;
        end else begin
            a_valid <= tag_tail.valid & ~bus.flush;
            if (tag_tail.valid) begin
                a_op   <= tag_tail.op;
                a_word <= tag_tail.word;
                a_lo   <= lo_sum[XLEN-1:0];
                a_cy   <= lo_sum[XLEN];
                a_s_hi <= bus.tree_s[2*XLEN-1:XLEN];
                a_c_hi <= bus.tree_c[2*XLEN-2:XLEN-1];
            end
        end
    end

    // Stage B is combinational off the stage-A registers and feeds the
    // result register directly; it is valid exactly when a_valid is.
    // Bits of P at 2*XLEN and above fall off the 64-bit sum.
    assign hi_sum = a_s_hi + a_c_hi + {{(XLEN-1){1'b0}}, a_cy};

    always_comb begin
        sel = hi_sum;
        if (a_word)          sel = sext_word(a_lo[31:0]);
        else if (a_op == MUL) sel = a_lo;
    end

    // Only one operation is ever in flight, so a_valid never coincides
    // with a held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
        end else if (bus.flush) begin
            res_valid_q <= 1'b0;
        end else if (a_valid) begin
            res_valid_q <= 1'b1;
            res_data_q  <= sel;
        end else if (res_valid_q && bus.res_ready) begin
            res_valid_q <= 1'b0;
        end
    end

    // res_ready term lets a new issue overlap the handoff cycle.
    assign busy = tag_busy | a_valid | (res_valid_q & ~bus.res_ready);

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.busy      = busy;

    ap_no_issue_when_busy : assert property (
        @(posedge clk) disable iff (!rst_n) !issue_dropped
    ) else $warning("issue_valid while busy: request dropped");

endmodule

// File: tb/tb_ysyx_22050518_mul_final_add.sv
module tb_ysyx_22050518_mul_final_add;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    ysyx_22050518_mul_final_add_if bus ();

    ysyx_22050518_mul_final_add dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [131:0] rand132();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[131:0];
    endfunction

    // Reference: P = s + 2*c mod 2^132, then pick the architectural field.
    function automatic logic [63:0] model(input logic [1:0] op, input logic word,
                                          input logic [131:0] s, input logic [131:0] c);
        logic [131:0] p;
        p = s + (c << 1);
        if (word)       return {{32{p[31]}}, p[31:0]};
        if (op == 2'd0) return p[63:0];
        return p[127:64];
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic junk();
        bus.tree_s = rand132();
        bus.tree_c = rand132();
    endtask

    // Issue in the current cycle T, present tree data only in cycle T+8,
    // and return in cycle T+10. Counts cycles T+1..T+9 where busy was low
    // or res_valid was already high.
    task automatic do_issue(input logic [1:0] op, input logic word,
                            input logic [131:0] s, input logic [131:0] c,
                            output int busy_lo, output int early);
        bus.issue_valid = 1'b1;
        bus.issue_op    = op;
        bus.issue_word  = word;
        junk();
        cyc();
        bus.issue_valid = 1'b0;
        bus.issue_op    = 2'($urandom_range(0, 3));
        bus.issue_word  = 1'($urandom_range(0, 1));
        busy_lo = 0;
        early   = 0;
        for (int k = 1; k <= 9; k++) begin
            if (!bus.busy) busy_lo++;
            if (bus.res_valid) early++;
            if (k == 8) begin
                bus.tree_s = s;
                bus.tree_c = c;
            end else begin
                junk();
            end
            cyc();
        end
        junk();
    endtask

    task automatic test_reset();
        n_checks++;
        if (bus.res_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_res_valid: got %b want 0", bus.res_valid);
        end
        n_checks++;
        if (bus.res_data !== 64'd0) begin
            n_fail++; $display("FAIL reset_res_data: got %h want 0", bus.res_data);
        end
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_basic_mul();
        int bl, ea;
        bus.res_ready = 1'b0;
        do_issue(2'd0, 1'b0, 132'd15, 132'd0, bl, ea);
        n_checks++;
        if (bl !== 0) begin n_fail++; $display("FAIL basic_busy_window: low cycles %0d want 0", bl); end
        n_checks++;
        if (ea !== 0) begin n_fail++; $display("FAIL basic_early_valid: cycles %0d want 0", ea); end
        n_checks++;
        if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid_t10: got %b want 1", bus.res_valid); end
        n_checks++;
        if (bus.res_data !== 64'd15) begin n_fail++; $display("FAIL basic_data: got %h want 15", bus.res_data); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_t10: got %b want 1", bus.busy); end
        bus.res_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy_ready: got %b want 0", bus.busy); end
        cyc();
        n_checks++;
        if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL basic_valid_drop: got %b want 0", bus.res_valid); end
    endtask

    task automatic test_cross_carry();
        logic [1:0]   ops  [4];
        logic [131:0] ss   [4];
        logic [131:0] cs   [4];
        logic [63:0]  want [4];
        int bl, ea;
        ops[0] = 2'd0; ss[0] = 132'hFFFF_FFFF_FFFF_FFFE; cs[0] = 132'd1; want[0] = 64'd0;
        ops[1] = 2'd3; ss[1] = 132'hFFFF_FFFF_FFFF_FFFE; cs[1] = 132'd1; want[1] = 64'd1;
        ops[2] = 2'd1; ss[2] = {4'hF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE};
        cs[2] = 132'd1; want[2] = 64'd0;
        ops[3] = 2'd3; ss[3] = 132'd5 << 64; cs[3] = 132'd1 << 127; want[3] = 64'd5;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            do_issue(ops[i], 1'b0, ss[i], cs[i], bl, ea);
            n_checks++;
            if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL carry_valid[%0d]: got %b want 1", i, bus.res_valid); end
            n_checks++;
            if (bus.res_data !== want[i]) begin n_fail++; $display("FAIL carry_data[%0d]: got %h want %h", i, bus.res_data, want[i]); end
            cyc();
        end
    endtask

    task automatic test_mulw();
        logic [1:0]   ops  [3];
        logic [131:0] ss   [3];
        logic [131:0] cs   [3];
        logic [63:0]  want [3];
        int bl, ea;
        ops[0] = 2'd3; ss[0] = 132'h4000_0000; cs[0] = 132'h2000_0000; want[0] = 64'hFFFF_FFFF_8000_0000;
        ops[1] = 2'd0; ss[1] = 132'h8000_0000; cs[1] = 132'd0;         want[1] = 64'hFFFF_FFFF_8000_0000;
        ops[2] = 2'd1; ss[2] = 132'h1234_0000_7FFF_FFFF; cs[2] = 132'd0; want[2] = 64'h0000_0000_7FFF_FFFF;
        bus.res_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            do_issue(ops[i], 1'b1, ss[i], cs[i], bl, ea);
            n_checks++;
            if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL mulw_valid[%0d]: got %b want 1", i, bus.res_valid); end
            n_checks++;
            if (bus.res_data !== want[i]) begin n_fail++; $display("FAIL mulw_data[%0d]: got %h want %h", i, bus.res_data, want[i]); end
            cyc();
        end
    endtask

    task automatic test_random();
        logic [1:0]   op;
        logic         word;
        logic [131:0] s, c;
        logic [63:0]  want;
        int bl, ea;
        for (int i = 0; i < 24; i++) begin
            op   = 2'($urandom_range(0, 3));
            word = ($urandom_range(0, 3) == 0);
            s    = rand132();
            c    = rand132();
            want = model(op, word, s, c);
            bus.res_ready = 1'($urandom_range(0, 1));
            do_issue(op, word, s, c, bl, ea);
            n_checks++;
            if (bl !== 0 || ea !== 0) begin n_fail++; $display("FAIL rand_timing[%0d]: busy_lo %0d early %0d want 0 0", i, bl, ea); end
            n_checks++;
            if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid[%0d]: got %b want 1", i, bus.res_valid); end
            n_checks++;
            if (bus.res_data !== want) begin n_fail++; $display("FAIL rand_data[%0d]: got %h want %h", i, bus.res_data, want); end
            bus.res_ready = 1'b1;
            cyc();
        end
    endtask

    task automatic test_back_to_back();
        logic [131:0] s1, c1, s2, c2;
        logic [63:0]  want1, want2;
        int bl, ea;
        s1 = rand132(); c1 = rand132();
        s2 = rand132(); c2 = rand132();
        want1 = model(2'd3, 1'b0, s1, c1);
        want2 = model(2'd0, 1'b0, s2, c2);
        bus.res_ready = 1'b0;
        do_issue(2'd3, 1'b0, s1, c1, bl, ea);
        for (int w = 0; w < 5; w++) begin
            n_checks++;
            if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_valid[%0d]: got %b want 1", w, bus.res_valid); end
            n_checks++;
            if (bus.res_data !== want1) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", w, bus.res_data, want1); end
            n_checks++;
            if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL bp_busy[%0d]: got %b want 1", w, bus.busy); end
            if (w == 2) begin
                bus.issue_valid = 1'b1;
                bus.issue_op    = 2'd0;
                bus.issue_word  = 1'b0;
                #1;
                n_checks++;
                if (dut.issue_dropped !== 1'b1) begin n_fail++; $display("FAIL bp_drop_flag: got %b want 1", dut.issue_dropped); end
            end
            junk();
            cyc();
            bus.issue_valid = 1'b0;
        end
        bus.res_ready = 1'b1;
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL bp_handoff_busy: got %b want 0", bus.busy); end
        do_issue(2'd0, 1'b0, s2, c2, bl, ea);
        n_checks++;
        if (ea !== 0) begin n_fail++; $display("FAIL bp_stray_result: cycles %0d want 0", ea); end
        n_checks++;
        if (bl !== 0) begin n_fail++; $display("FAIL bp_second_busy: low cycles %0d want 0", bl); end
        n_checks++;
        if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL bp_second_valid: got %b want 1", bus.res_valid); end
        n_checks++;
        if (bus.res_data !== want2) begin n_fail++; $display("FAIL bp_second_data: got %h want %h", bus.res_data, want2); end
        cyc();
    endtask

    task automatic test_flush();
        int seen;
        bus.res_ready   = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_op    = 2'd0;
        bus.issue_word  = 1'b0;
        cyc();
        bus.issue_valid = 1'b0;
        for (int k = 1; k < 4; k++) begin junk(); cyc(); end
        bus.flush = 1'b1;
        junk();
        cyc();
        bus.flush = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_t5: got %b want 0", bus.busy); end
        bus.issue_valid = 1'b1;
        bus.flush       = 1'b1;
        cyc();
        bus.issue_valid = 1'b0;
        bus.flush       = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_over_issue_busy: got %b want 0", bus.busy); end
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            if (bus.res_valid) seen++;
            junk();
            cyc();
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL flush_no_result: valid cycles %0d want 0", seen); end
    endtask

    task automatic test_async_reset();
        int seen;
        bus.res_ready   = 1'b1;
        bus.issue_valid = 1'b1;
        bus.issue_op    = 2'd3;
        bus.issue_word  = 1'b0;
        cyc();
        bus.issue_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin junk(); cyc(); end
        n_checks++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL arst_busy_before: got %b want 1", bus.busy); end
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL arst_valid: got %b want 0", bus.res_valid); end
        n_checks++;
        if (bus.res_data !== 64'd0) begin n_fail++; $display("FAIL arst_data: got %h want 0", bus.res_data); end
        n_checks++;
        if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL arst_busy: got %b want 0", bus.busy); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 14; k++) begin
            cyc();
            if (bus.res_valid || bus.busy) seen++;
            junk();
        end
        n_checks++;
        if (seen !== 0) begin n_fail++; $display("FAIL arst_no_result: active cycles %0d want 0", seen); end
    endtask

    task automatic test_recover();
        logic [131:0] s, c;
        logic [63:0]  want;
        int bl, ea;
        s = rand132(); c = rand132();
        want = model(2'd2, 1'b0, s, c);
        bus.res_ready = 1'b1;
        do_issue(2'd2, 1'b0, s, c, bl, ea);
        n_checks++;
        if (bus.res_valid !== 1'b1 || bus.res_data !== want) begin
            n_fail++; $display("FAIL recover_data: valid %b data %h want 1 %h", bus.res_valid, bus.res_data, want);
        end
        cyc();
    endtask

    initial begin
        n_checks        = 0;
        n_fail          = 0;
        rst_n           = 1'b0;
        bus.issue_valid = 1'b0;
        bus.issue_op    = 2'd0;
        bus.issue_word  = 1'b0;
        bus.flush       = 1'b0;
        bus.tree_s      = '0;
        bus.tree_c      = '0;
        bus.res_ready   = 1'b0;
        #23;
        test_reset();
        rst_n = 1'b1;
        cyc();
        test_basic_mul();
        test_cross_carry();
        test_mulw();
        test_random();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_recover();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
